div_iter: RTL and testbench

//  Iterative radix-2 restoring divider for the EX stage; companion to the multiplier, serving DIV/DIVU.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 16 +
 rtl/div_iter.sv | 111 +++++++++++
 tb/tb_div_iter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types, sizes and sign helpers for the iterative divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITER = 32;
   function automatic logic [DIV_WIDTH-1:0] div_neg(input logic [DIV_WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction
   function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] x, input logic s);
      return (s && x[DIV_WIDTH-1]) ? div_neg(x) : x;
   endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on a WIDTH+1-bit shifted remainder.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_out,
   output logic             qbit
);
   logic [WIDTH:0] sh, diff;
   assign sh = {rem_in, dvd_msb};
   assign diff = sh - {1'b0, dvs};
   assign qbit = sh >= {1'b0, dvs};
   assign rem_out = WIDTH'(qbit ? diff : sh);
endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider for DIV/DIVU, remainder on hi, quotient on lo.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and |src1|<|src2| in one cycle.
module div_iter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int ITER  = DIV_ITER
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             div_sign,
   input  logic             div_start,
   input  logic             div_cancel,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_busy,
   output logic             finish_div
);
   localparam int CW = $clog2(ITER);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);
   div_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dq_q, dq_d, rem_q, rem_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
   logic negq_q, negq_d, negr_q, negr_d;
   logic [WIDTH-1:0] a1, a2, rem_step;
   logic qbit;
   assign a1 = div_abs(src1, div_sign);
   assign a2 = div_abs(src2, div_sign);
   // dq_q shifts the dividend out of its MSB while quotient bits enter at the LSB
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in (rem_q),
      .dvd_msb(dq_q[WIDTH-1]),
      .dvs    (dvs_q),
      .rem_out(rem_step),
      .qbit   (qbit)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dq_d = dq_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      negq_d = negq_q;
      negr_d = negr_q;
      hi_d = hi_q;
      lo_d = lo_q;
      case (state_q)
         IDLE: if (div_start && !div_cancel) begin
            dq_d = a1;
            dvs_d = a2;
            rem_d = '0;
            cnt_d = '0;
            negq_d = div_sign & (src1[WIDTH-1] ^ src2[WIDTH-1]);
            negr_d = div_sign & src1[WIDTH-1];
            state_d = CALC;
`ifdef DIV_EARLY_OUT_EN
            if (src2 == '0 || a1 < a2) begin
               state_d = DONE;
               lo_d = (src2 == '0) ? '1 : '0;
               hi_d = src1;
            end
`endif
         end
         CALC: if (div_cancel) state_d = IDLE;
         else begin
            dq_d = {dq_q[WIDTH-2:0], qbit};
            rem_d = rem_step;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? FIX : CALC;
         end
         // a zero divisor leaves rem=|src1|, so the remainder fix restores src1 exactly
         FIX: if (div_cancel) state_d = IDLE;
         else begin
            lo_d = (dvs_q == '0) ? '1 : negq_q ? div_neg(dq_q) : dq_q;
            hi_d = negr_q ? div_neg(rem_q) : rem_q;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         dq_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dq_q <= dq_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
   assign hi = hi_q;
   assign lo = lo_q;
   assign div_busy = state_q != IDLE;
   assign finish_div = state_q == DONE;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter, one task per scenario.
module tb_div_iter;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_EO = 1;
`else
   localparam int LAT_EO = 34;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] src1 = '0, src2 = '0;
   logic div_sign = 1'b0, div_start = 1'b0, div_cancel = 1'b0;
   logic [31:0] hi, lo;
   logic div_busy, finish_div;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   div_iter dut (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .div_sign(div_sign),
      .div_start(div_start), .div_cancel(div_cancel), .hi(hi), .lo(lo),
      .div_busy(div_busy), .finish_div(finish_div)
   );
   task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat, output logic busy1);
      @(negedge clk);
      src1 = a;
      src2 = b;
      div_sign = s;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      busy1 = div_busy;
      lat = 1;
      while (!finish_div && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (!finish_div) lat = -1;
   endtask
   task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input int exp_lat, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
      int lat;
      logic b1;
      go(a, b, s, lat, b1);
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
      checks++;
      if (lo !== exp_lo) begin errors++; $display("FAIL %s lo got %h want %h", name, lo, exp_lo); end
      checks++;
      if (hi !== exp_hi) begin errors++; $display("FAIL %s hi got %h want %h", name, hi, exp_hi); end
      checks++;
      if (b1 !== 1'b1 || div_busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b/%b want 1/1", name, b1, div_busy); end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({hi, lo, div_busy, finish_div} !== '0) begin errors++; $display("FAIL reset got hi=%h lo=%h busy=%b fin=%b want 0", hi, lo, div_busy, finish_div); end
      rst = 1'b0;
   endtask
   task automatic test_unsigned;
      check_op("u100_7", 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2);
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b0 || finish_div !== 1'b0) begin errors++; $display("FAIL u_idle busy=%b fin=%b want 0/0", div_busy, finish_div); end
      check_op("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 34, 32'h7FFF_FFFC, 32'd1);
   endtask
   task automatic test_signed;
      check_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      check_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 34, 32'hFFFF_FFFD, 32'd1);
      check_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, 32'h8000_0000, 32'd0);
   endtask
   task automatic test_div0;
      check_op("div0_u", 32'h1234, 32'd0, 1'b0, LAT_EO, 32'hFFFF_FFFF, 32'h1234);
      check_op("div0_s", 32'h1234, 32'd0, 1'b1, LAT_EO, 32'hFFFF_FFFF, 32'h1234);
      check_op("div0_sneg", 32'hFFFF_FF00, 32'd0, 1'b1, LAT_EO, 32'hFFFF_FFFF, 32'hFFFF_FF00);
   endtask
   task automatic test_cancel;
      int k;
      int fins;
      logic [31:0] plo, phi;
      int lat;
      logic b1;
      check_op("pre_cancel", 32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2);
      plo = lo;
      phi = hi;
      @(negedge clk);
      src1 = 32'd1000;
      src2 = 32'd3;
      div_sign = 1'b0;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      fins = 0;
      for (k = 1; k < 10; k++) begin
         if (finish_div) fins++;
         @(negedge clk);
      end
      div_cancel = 1'b1;
      @(negedge clk);
      div_cancel = 1'b0;
      checks++;
      if (div_busy !== 1'b0 || fins != 0 || finish_div !== 1'b0) begin errors++; $display("FAIL cancel busy=%b fins=%0d want 0/0", div_busy, fins); end
      checks++;
      if (lo !== plo || hi !== phi) begin errors++; $display("FAIL cancel_hold lo=%h hi=%h want %h %h", lo, hi, plo, phi); end
      src1 = 32'd1000;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      lat = 1;
      while (!finish_div && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (!finish_div || lat != 34 || lo !== 32'd333 || hi !== 32'd1) begin errors++; $display("FAIL after_cancel fin=%b lat=%0d lo=%0d hi=%0d want lat 34 lo 333 hi 1", finish_div, lat, lo, hi); end
      @(negedge clk);
      div_start = 1'b1;
      div_cancel = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      div_cancel = 1'b0;
      checks++;
      if (div_busy !== 1'b0) begin errors++; $display("FAIL cancel_start busy=%b want 0", div_busy); end
      b1 = 1'b0;
      go(32'd9, 32'd2, 1'b0, lat, b1);
      checks++;
      if (lat != 34 || lo !== 32'd4 || hi !== 32'd1) begin errors++; $display("FAIL post_cs lat=%0d lo=%0d hi=%0d want 34 4 1", lat, lo, hi); end
   endtask
   task automatic test_reset_mid;
      int fins;
      @(negedge clk);
      src1 = 32'd50;
      src2 = 32'd5;
      div_sign = 1'b0;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (hi !== '0 || lo !== '0 || div_busy !== 1'b0) begin errors++; $display("FAIL rst_mid hi=%h lo=%h busy=%b want 0", hi, lo, div_busy); end
      src1 = 32'd100;
      src2 = 32'd7;
      div_start = 1'b1;
      @(negedge clk);
      div_start = 1'b0;
      fins = 0;
      for (int k = 1; k <= 80; k++) begin
         if (finish_div) fins++;
         if (k == 5) begin src1 = 32'd200; src2 = 32'd3; div_start = 1'b1; end
         if (k == 6) div_start = 1'b0;
         if (k == 20) src2 = 32'd1;
         @(negedge clk);
      end
      checks++;
      if (fins != 1 || lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL busy_start fins=%0d lo=%0d hi=%0d want 1 14 2", fins, lo, hi); end
   endtask
   task automatic test_early;
      check_op("eo_3_10", 32'd3, 32'd10, 1'b0, LAT_EO, 32'd0, 32'd3);
      check_op("eo_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, LAT_EO, 32'd0, 32'hFFFF_FFFD);
   endtask
   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div0();
      test_cancel();
      test_reset_mid();
      test_early();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
